// File: rtl/tlul_pkg.sv
// TL-UL channel structs shared by hosts, devices and the host arbiter.
package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/xbar_pkg.sv
// Host indices and sizing defaults for the IF/LSU host arbiter.
package xbar_pkg;

    localparam logic        HOST_IF               = 1'b0;
    localparam logic        HOST_LSU              = 1'b1;
    localparam int unsigned MaxOutstandingDefault = 4;

endpackage

// File: rtl/tlul_host_arb_idq.sv
// In-order host-ID queue: one bit per accepted request, popped as responses return.
module tlul_host_arb_idq #(
    parameter int unsigned Depth = 4,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            id_i,
    input  logic            pop_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o,
    output logic            head_o
);

    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    // Depth need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= id_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tlul_host_arb2.sv
// 2:1 TL-UL host arbiter (IF = host 0, LSU = host 1) onto one downstream port,
// with round-robin grant, stall lock and in-order D-channel return routing.
module tlul_host_arb2
    import tlul_pkg::*;
    import xbar_pkg::*;
#(
    parameter int unsigned MaxOutstanding = MaxOutstandingDefault,
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  tl_h2d_t         tl_if_i,
    output tl_d2h_t         tl_if_o,
    input  tl_h2d_t         tl_lsu_i,
    output tl_d2h_t         tl_lsu_o,
    output tl_h2d_t         tl_dev_o,
    input  tl_d2h_t         tl_dev_i,
    output logic [CntW-1:0] outstanding_o,
    output logic            spurious_rsp_o
);

    logic    grant;
    logic    rr_q;
    logic    lock_q;
    logic    lock_host_q;
    logic    q_full;
    logic    q_empty;
    logic    q_head;
    logic    a_fire;
    logic    d_fire;
    tl_h2d_t gnt_req;

    always_comb begin
        grant = rr_q;
        if (lock_q) begin
            grant = lock_host_q;
        end else if (tl_if_i.a_valid && !tl_lsu_i.a_valid) begin
            grant = HOST_IF;
        end else if (!tl_if_i.a_valid && tl_lsu_i.a_valid) begin
            grant = HOST_LSU;
        end
    end

    assign gnt_req = (grant == HOST_LSU) ? tl_lsu_i : tl_if_i;

    // With the queue empty there is no owner for a response, so it is sunk here.
    always_comb begin
        tl_dev_o         = gnt_req;
        tl_dev_o.a_valid = gnt_req.a_valid & ~q_full;
        tl_dev_o.d_ready = q_empty ? 1'b1
                         : ((q_head == HOST_LSU) ? tl_lsu_i.d_ready : tl_if_i.d_ready);
    end

    assign a_fire = tl_dev_o.a_valid & tl_dev_i.a_ready;
    assign d_fire = tl_dev_i.d_valid & tl_dev_o.d_ready & ~q_empty;

    always_comb begin
        tl_if_o          = tl_dev_i;
        tl_if_o.d_valid  = tl_dev_i.d_valid & ~q_empty & (q_head == HOST_IF);
        tl_if_o.a_ready  = (grant == HOST_IF) & tl_dev_i.a_ready & ~q_full;
        tl_lsu_o         = tl_dev_i;
        tl_lsu_o.d_valid = tl_dev_i.d_valid & ~q_empty & (q_head == HOST_LSU);
        tl_lsu_o.a_ready = (grant == HOST_LSU) & tl_dev_i.a_ready & ~q_full;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q           <= HOST_IF;
            lock_q         <= 1'b0;
            lock_host_q    <= HOST_IF;
            spurious_rsp_o <= 1'b0;
        end else begin
            if (a_fire) begin
                rr_q <= ~grant;
            end
            // Hold the grant while the presented request is stalled downstream.
            lock_q <= tl_dev_o.a_valid & ~tl_dev_i.a_ready;
            if (tl_dev_o.a_valid && !tl_dev_i.a_ready) begin
                lock_host_q <= grant;
            end
            spurious_rsp_o <= tl_dev_i.d_valid & q_empty;
        end
    end

    tlul_host_arb_idq #(
        .Depth (MaxOutstanding)
    ) u_idq (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (a_fire),
        .id_i    (grant),
        .pop_i   (d_fire),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (outstanding_o),
        .head_o  (q_head)
    );

endmodule

// File: tb/tb_tlul_host_arb2.sv
// Directed self-checking bench for tlul_host_arb2 (MaxOutstanding = 4).
module tb_tlul_host_arb2;
    import tlul_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ni;
    tl_h2d_t    h_if;
    tl_h2d_t    h_lsu;
    tl_h2d_t    dev_req;
    tl_d2h_t    r_if;
    tl_d2h_t    r_lsu;
    tl_d2h_t    dev_rsp;
    logic [2:0] outstanding;
    logic       spurious;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    tlul_host_arb2 #(.MaxOutstanding(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .tl_if_i        (h_if),
        .tl_if_o        (r_if),
        .tl_lsu_i       (h_lsu),
        .tl_lsu_o       (r_lsu),
        .tl_dev_o       (dev_req),
        .tl_dev_i       (dev_rsp),
        .outstanding_o  (outstanding),
        .spurious_rsp_o (spurious)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        h_if            = '0;
        h_lsu           = '0;
        dev_rsp         = '0;
        h_if.d_ready    = 1'b1;
        h_lsu.d_ready   = 1'b1;
        h_if.a_source   = 8'h10;
        h_lsu.a_source  = 8'h20;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_all();
        dev_rsp.d_valid = 1'b1;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        checks++; if ({r_if.d_valid, r_lsu.d_valid} !== 2'b00) begin errors++; $display("FAIL reset_host_dvalid: got %b want 00", {r_if.d_valid, r_lsu.d_valid}); end
        checks++; if (dev_req.a_valid !== 1'b0) begin errors++; $display("FAIL reset_dev_avalid: got %b want 0", dev_req.a_valid); end
        step(); step();
        checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL reset_spurious: got %b want 0", spurious); end
        dev_rsp.d_valid = 1'b0;
        rst_ni = 1'b1;
        step();
        $display("txn reset: released");
    endtask

    task automatic test_alternate();
        logic        exp_host;
        logic        prev_host;
        logic [31:0] prev_data;
        idle_all();
        h_if.a_valid    = 1'b1;
        h_if.a_address  = 32'h0000_0100;
        h_lsu.a_valid   = 1'b1;
        h_lsu.a_address = 32'h1000_0000;
        dev_rsp.a_ready = 1'b1;
        prev_host = 1'b0;
        prev_data = '0;
        for (int i = 0; i < 5; i++) begin
            exp_host = i[0];
            dev_rsp.d_valid = (i > 0);
            dev_rsp.d_data  = prev_data;
            dev_rsp.d_source = prev_host ? 8'h20 : 8'h10;
            if (i == 4) begin
                h_if.a_valid  = 1'b0;
                h_lsu.a_valid = 1'b0;
            end
            #1;
            if (i < 4) begin
                checks++; if (dev_req.a_source !== (exp_host ? 8'h20 : 8'h10)) begin errors++; $display("FAIL alt_grant[%0d]: got src %h want %h", i, dev_req.a_source, exp_host ? 8'h20 : 8'h10); end
                checks++; if ({r_if.a_ready, r_lsu.a_ready} !== (exp_host ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_aready[%0d]: got %b", i, {r_if.a_ready, r_lsu.a_ready}); end
                $display("txn alt %0d: host=%0d addr=%h", i, exp_host, dev_req.a_address);
            end
            if (i > 0) begin
                checks++; if ({r_if.d_valid, r_lsu.d_valid} !== (prev_host ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_droute[%0d]: got %b", i, {r_if.d_valid, r_lsu.d_valid}); end
                checks++; if ((prev_host ? r_lsu.d_data : r_if.d_data) !== prev_data) begin errors++; $display("FAIL alt_ddata[%0d]: got %h want %h", i, prev_host ? r_lsu.d_data : r_if.d_data, prev_data); end
            end
            checks++; if (outstanding !== ((i == 0) ? 3'd0 : 3'd1)) begin errors++; $display("FAIL alt_outstanding[%0d]: got %0d", i, outstanding); end
            prev_host = exp_host;
            prev_data = 32'hD000_0000 + 32'(i);
            step();
        end
        idle_all();
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL alt_drain: got %0d want 0", outstanding); end
    endtask

    task automatic test_lock();
        idle_all();
        h_lsu.a_valid   = 1'b1;
        h_lsu.a_address = 32'h1000_0004;
        h_lsu.a_source  = 8'h21;
        dev_rsp.a_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                h_if.a_valid   = 1'b1;
                h_if.a_address = 32'h0000_0200;
                h_if.a_source  = 8'h11;
            end
            if (c == 3) dev_rsp.a_ready = 1'b1;
            #1;
            checks++; if (dev_req.a_address !== 32'h1000_0004) begin errors++; $display("FAIL lock_addr[%0d]: got %h want 10000004", c, dev_req.a_address); end
            checks++; if ({r_if.a_ready, r_lsu.a_ready} !== ((c == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL lock_aready[%0d]: got %b", c, {r_if.a_ready, r_lsu.a_ready}); end
            $display("txn lock %0d: addr=%h dev_a_ready=%b", c, dev_req.a_address, dev_rsp.a_ready);
            step();
        end
        h_lsu.a_valid = 1'b0;
        #1;
        checks++; if (dev_req.a_address !== 32'h0000_0200 || r_if.a_ready !== 1'b1) begin errors++; $display("FAIL lock_next_if: got addr %h a_ready %b", dev_req.a_address, r_if.a_ready); end
        step();
        h_if.a_valid    = 1'b0;
        dev_rsp.d_valid = 1'b1;
        dev_rsp.d_data  = 32'h51;
        #1;
        checks++; if (r_lsu.d_valid !== 1'b1 || r_lsu.d_data !== 32'h51 || r_if.d_valid !== 1'b0) begin errors++; $display("FAIL lock_rsp_lsu: got v %b d %h", r_lsu.d_valid, r_lsu.d_data); end
        step();
        dev_rsp.d_data = 32'h52;
        #1;
        checks++; if (r_if.d_valid !== 1'b1 || r_if.d_data !== 32'h52 || r_lsu.d_valid !== 1'b0) begin errors++; $display("FAIL lock_rsp_if: got v %b d %h", r_if.d_valid, r_if.d_data); end
        step();
        idle_all();
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL lock_drain: got %0d want 0", outstanding); end
    endtask

    task automatic test_full();
        idle_all();
        dev_rsp.a_ready = 1'b1;
        h_if.a_valid    = 1'b1;
        h_if.a_source   = 8'h12;
        for (int i = 0; i < 5; i++) begin
            h_if.a_address = 32'h0000_0300 + 32'(4 * i);
            #1;
            checks++; if (r_if.a_ready !== (i < 4)) begin errors++; $display("FAIL full_aready[%0d]: got %b", i, r_if.a_ready); end
            checks++; if (outstanding !== 3'(i)) begin errors++; $display("FAIL full_count[%0d]: got %0d want %0d", i, outstanding, i); end
            $display("txn full %0d: addr=%h a_ready=%b", i, h_if.a_address, r_if.a_ready);
            if (i < 4) step();
        end
        checks++; if (dev_req.a_valid !== 1'b0) begin errors++; $display("FAIL full_dev_avalid: got %b want 0", dev_req.a_valid); end
        step();
        dev_rsp.d_valid = 1'b1;
        #1;
        checks++; if (r_if.a_ready !== 1'b0 || r_if.d_valid !== 1'b1) begin errors++; $display("FAIL full_pop_no_push: got a_ready %b d_valid %b", r_if.a_ready, r_if.d_valid); end
        step();
        dev_rsp.d_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd3 || r_if.a_ready !== 1'b1 || dev_req.a_address !== 32'h0000_0310) begin errors++; $display("FAIL full_fifth: got cnt %0d a_ready %b addr %h", outstanding, r_if.a_ready, dev_req.a_address); end
        step();
        h_if.a_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d want 4", outstanding); end
        dev_rsp.d_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (r_if.d_valid !== 1'b1 || r_lsu.d_valid !== 1'b0) begin errors++; $display("FAIL full_drain[%0d]: got %b", i, {r_if.d_valid, r_lsu.d_valid}); end
            step();
        end
        dev_rsp.d_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d want 0", outstanding); end
    endtask

    task automatic test_interleave();
        idle_all();
        dev_rsp.a_ready = 1'b1;
        h_if.a_valid = 1'b1;
        #1;
        checks++; if (r_if.a_ready !== 1'b1) begin errors++; $display("FAIL ilv_req0: got %b want 1", r_if.a_ready); end
        step();
        h_if.a_valid  = 1'b0;
        h_lsu.a_valid = 1'b1;
        #1;
        checks++; if (r_lsu.a_ready !== 1'b1) begin errors++; $display("FAIL ilv_req1: got %b want 1", r_lsu.a_ready); end
        step();
        h_lsu.a_valid = 1'b0;
        h_if.a_valid  = 1'b1;
        #1;
        checks++; if (r_if.a_ready !== 1'b1) begin errors++; $display("FAIL ilv_req2: got %b want 1", r_if.a_ready); end
        step();
        h_if.a_valid    = 1'b0;
        dev_rsp.a_ready = 1'b0;
        dev_rsp.d_valid = 1'b1;
        dev_rsp.d_data  = 32'hA;
        h_if.d_ready    = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL ilv_count: got %0d want 3", outstanding); end
        checks++; if (dev_req.d_ready !== 1'b0 || r_if.d_valid !== 1'b1) begin errors++; $display("FAIL ilv_stall: got d_ready %b if_d_valid %b", dev_req.d_ready, r_if.d_valid); end
        step();
        checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL ilv_stall_hold: got %0d want 3", outstanding); end
        h_if.d_ready = 1'b1;
        #1;
        checks++; if (dev_req.d_ready !== 1'b1 || r_if.d_data !== 32'hA) begin errors++; $display("FAIL ilv_rsp_a: got d_ready %b data %h", dev_req.d_ready, r_if.d_data); end
        $display("txn ilv: IF rsp %h", r_if.d_data);
        step();
        dev_rsp.d_data = 32'hB;
        #1;
        checks++; if (r_lsu.d_valid !== 1'b1 || r_if.d_valid !== 1'b0 || r_lsu.d_data !== 32'hB) begin errors++; $display("FAIL ilv_rsp_b: got lsu v %b d %h if v %b", r_lsu.d_valid, r_lsu.d_data, r_if.d_valid); end
        $display("txn ilv: LSU rsp %h", r_lsu.d_data);
        step();
        dev_rsp.d_data = 32'hC;
        #1;
        checks++; if (r_if.d_valid !== 1'b1 || r_lsu.d_valid !== 1'b0 || r_if.d_data !== 32'hC) begin errors++; $display("FAIL ilv_rsp_c: got if v %b d %h lsu v %b", r_if.d_valid, r_if.d_data, r_lsu.d_valid); end
        $display("txn ilv: IF rsp %h", r_if.d_data);
        step();
        dev_rsp.d_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL ilv_drain: got %0d want 0", outstanding); end
    endtask

    task automatic test_spurious();
        idle_all();
        dev_rsp.d_valid = 1'b1;
        dev_rsp.d_data  = 32'hEE;
        #1;
        checks++; if (dev_req.d_ready !== 1'b1) begin errors++; $display("FAIL spur_dready: got %b want 1", dev_req.d_ready); end
        checks++; if ({r_if.d_valid, r_lsu.d_valid} !== 2'b00) begin errors++; $display("FAIL spur_host_dvalid: got %b want 00", {r_if.d_valid, r_lsu.d_valid}); end
        step();
        dev_rsp.d_valid = 1'b0;
        #1;
        checks++; if (spurious !== 1'b1 || outstanding !== 3'd0) begin errors++; $display("FAIL spur_pulse: got pulse %b cnt %0d", spurious, outstanding); end
        $display("txn spurious: beat dropped");
        step();
        checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL spur_width: got %b want 0", spurious); end
    endtask

    task automatic test_reset_mid();
        idle_all();
        dev_rsp.a_ready = 1'b1;
        h_if.a_valid    = 1'b1;
        step(); step(); step();
        h_if.a_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL rst_mid_fill: got %0d want 3", outstanding); end
        rst_ni = 1'b0;
        dev_rsp.d_valid = 1'b1;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", outstanding); end
        checks++; if ({dev_req.a_valid, r_if.d_valid, r_lsu.d_valid} !== 3'b000) begin errors++; $display("FAIL rst_mid_valids: got %b want 000", {dev_req.a_valid, r_if.d_valid, r_lsu.d_valid}); end
        step();
        rst_ni = 1'b1;
        dev_rsp.d_valid = 1'b0;
        step();
        h_if.a_valid  = 1'b1;
        h_lsu.a_valid = 1'b1;
        #1;
        checks++; if ({r_if.a_ready, r_lsu.a_ready} !== 2'b10 || dev_req.a_source !== 8'h10) begin errors++; $display("FAIL rst_mid_rr: got ready %b src %h want 10/10", {r_if.a_ready, r_lsu.a_ready}, dev_req.a_source); end
        $display("txn reset_mid: grant src=%h", dev_req.a_source);
        step();
        idle_all();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alternate();
        test_lock();
        test_full();
        test_interleave();
        test_spurious();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
